dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of REQ-state cycles allowed without bus_ack.
REQ-002 Port clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port mem_re  input  1  SHALL be the core load request.
REQ-005 Port mem_we  input  1  SHALL be the core store request.
REQ-006 Port addr  input  32  SHALL be the core byte address, driven from the ALU result.
REQ-007 Port wd  input  32  SHALL be the core store data, driven from register-file read port 1.
REQ-008 Port rd  output  32  SHALL be the load data returned to the core result mux.
REQ-009 Port stall  output  1  SHALL freeze the core PC and register-file write while high.
REQ-010 Port bus_req  output  1  SHALL be the bus request.
REQ-011 Port bus_we  output  1  SHALL mark a bus write.
REQ-012 Port bus_addr  output  32  SHALL be the bus address.
REQ-013 Port bus_wdata  output  32  SHALL be the bus write data.
REQ-014 Port bus_ack  input  1  SHALL be the bus completion strobe.
REQ-015 Port bus_rdata  input  32  SHALL be the bus read data, valid with bus_ack.
REQ-016 Port err  output  1  SHALL be a sticky error flag.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ and RESP.
REQ-018 IDLE, (mem_re|mem_we)=1: latch addr, wd and mem_we into bus_addr, bus_wdata and bus_we; move to REQ.
REQ-019 If mem_re and mem_we are both 1, the access SHALL be a store.
REQ-020 stall SHALL be combinational: 1 when (state==IDLE and (mem_re|mem_we)) or state==REQ; otherwise 0.
REQ-021 bus_req SHALL be 1 exactly while state==REQ; bus_addr, bus_wdata and bus_we SHALL stay stable throughout REQ.
REQ-022 REQ with bus_ack=1: for a load, capture bus_rdata into rd; go to RESP; bus_req SHALL be 0 on the next cycle.
REQ-023 bus_ack received outside REQ SHALL be ignored.
REQ-024 RESP SHALL last exactly one cycle with stall=0, then return to IDLE; request inputs seen in RESP SHALL be ignored.
REQ-025 Minimum access latency, with ack in the first REQ cycle: 2 stall cycles, rd valid in the RESP cycle.
REQ-026 rd SHALL hold its last loaded value until the next load completes; stores SHALL not change rd.
REQ-027 A 16-bit wait counter SHALL clear on REQ entry and increment each REQ cycle without ack.
REQ-028 Counter == TIMEOUT with no ack: drop bus_req, set rd=0 for a load, set err, go to RESP.
REQ-029 err SHALL be sticky; it SHALL clear only on reset.

Reset
REQ-030 On reset, go to IDLE and clear rd, bus_addr, bus_wdata, bus_we, bus_req, err and the counter; all outputs SHALL be 0 on the following cycle.
REQ-031 Reset during REQ SHALL abandon the transaction; no rd or err update from it.

Configuration
REQ-032 With macro DMEM_ALIGN_CHECK_EN defined, an IDLE request with addr[1:0]!=0 SHALL:
  - skip REQ and go directly to RESP (1 stall cycle);
  - assert no bus_req;
  - set err;
  - leave rd unchanged.
REQ-033 Without DMEM_ALIGN_CHECK_EN, addr SHALL be forwarded unmodified, and no alignment logic SHALL exist.

Structure
REQ-034 The state enum (IDLE/REQ/RESP) and the TIMEOUT default constant SHALL live in the shared package mips_pkg.
REQ-035 The wait counter SHALL be sub-module wait_counter (inputs clear and enable; outputs count and expired).

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
  - Load, addr=0x10, ack in first REQ cycle with rdata=0xDEADBEEF -> stall high 2 cycles; rd=0xDEADBEEF in RESP; bus_we=0.
  - Store, addr=0x20, wd=0x12345678, ack after 3 wait cycles -> bus_we=1, bus_wdata=0x12345678 stable, stall high 5 cycles, rd unchanged.
  - mem_re=mem_we=1 -> store performed (bus_we=1).
  - No ack, TIMEOUT=4 -> bus_req drops after 5 REQ cycles; err=1; rd=0; FSM back to IDLE after RESP.
  - Reset asserted mid-REQ -> next cycle bus_req=0, stall=0 with no request, err=0; later ack ignored.
  - DMEM_ALIGN_CHECK_EN, load addr=0x13 -> no bus_req, stall 1 cycle, err=1; without the macro -> bus_addr=0x13.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encoding and
// default bus-timeout constants.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  localparam int DMEM_TIMEOUT = 255;
  localparam int WAIT_CNT_W   = 16;

endpackage

// File: rtl/wait_counter.sv
// Bus wait counter: cleared while idle, counts unacknowledged REQ cycles,
// flags when the count reaches LIMIT.
module wait_counter
  import mips_pkg::*;
#(
  parameter int LIMIT = DMEM_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  output logic [WAIT_CNT_W-1:0] count,
  output logic                  expired
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT_W = WAIT_CNT_W'(LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT_W);

endmodule

// File: rtl/dmem_bridge.sv
// Core-to-bus data memory bridge: stalls the core while a load/store runs
// on a req/ack bus, with timeout. Optional DMEM_ALIGN_CHECK_EN rejects
// misaligned word accesses without touching the bus.
module dmem_bridge
  import mips_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        err
);

  bridge_state_t state, next_state;

  logic                  access;
  logic                  expired;
  logic [WAIT_CNT_W-1:0] count_unused;

  assign access = mem_re | mem_we;

`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |addr[1:0];
`endif

  wait_counter #(
    .LIMIT(TIMEOUT)
  ) u_wait_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != REQ),
    .enable ((state == REQ) && !bus_ack),
    .count  (count_unused),
    .expired(expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (access) begin
`ifdef DMEM_ALIGN_CHECK_EN
          next_state = misaligned ? RESP : REQ;
`else
          next_state = REQ;
`endif
        end
      end
      REQ:     if (bus_ack || expired) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are latched once on acceptance and held for the whole
  // REQ phase; a store wins when both request lines are high.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd        <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
`ifdef DMEM_ALIGN_CHECK_EN
            if (misaligned) begin
              err <= 1'b1;
            end else begin
              bus_addr  <= addr;
              bus_wdata <= wd;
              bus_we    <= mem_we;
            end
`else
            bus_addr  <= addr;
            bus_wdata <= wd;
            bus_we    <= mem_we;
`endif
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (!bus_we) rd <= bus_rdata;
          end else if (expired) begin
            if (!bus_we) rd <= '0;
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_req = (state == REQ);
  assign stall   = ((state == IDLE) && access) || (state == REQ);

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge (TIMEOUT=4); expected values are
// hand-computed per scenario. Honours DMEM_ALIGN_CHECK_EN like the RTL.
module tb_dmem_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_re, mem_we;
  logic [31:0] addr, wd;
  logic [31:0] rd;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  int stall_cnt, req_cnt;
  bit stable_ok;

  dmem_bridge #(
    .TIMEOUT(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .stall    (stall),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .err      (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one request and holds it like a stalled core would; returns in
  // the RESP cycle (first unstalled cycle) with the request still applied.
  // ack_wait: number of unacknowledged REQ cycles before ack, <0 for never.
  task automatic run_access(input logic re, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input int ack_wait,
                            input logic [31:0] rdata);
    bit done;
    done      = 1'b0;
    stall_cnt = 0;
    req_cnt   = 0;
    stable_ok = 1'b1;
    mem_re    = re;
    mem_we    = we;
    addr      = a;
    wd        = d;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      bus_ack   = 1'b0;
      bus_rdata = 32'hFFFF_FFFF;
      if (bus_req) begin
        if (bus_addr !== a || bus_wdata !== d || bus_we !== we) stable_ok = 1'b0;
        if (req_cnt == ack_wait) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
        end
        req_cnt++;
      end
      #1;
      if (stall) stall_cnt++;
      if (cyc > 0 && !stall) done = 1'b1;
      else tick();
    end
    bus_ack = 1'b0;
    if (!done) check("access_budget", 32'd0, 32'd1);
  endtask

  task automatic end_access();
    tick();
    mem_re = 1'b0;
    mem_we = 1'b0;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    addr      = '0;
    wd        = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    check("rst_rd",        rd,        32'h0);
    check("rst_stall",     stall,     32'h0);
    check("rst_bus_req",   bus_req,   32'h0);
    check("rst_bus_we",    bus_we,    32'h0);
    check("rst_bus_addr",  bus_addr,  32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_err",       err,       32'h0);

    // Load with ack in the first REQ cycle.
    run_access(1'b1, 1'b0, 32'h10, 32'h0000_AAAA, 0, 32'hDEAD_BEEF);
    check("ld_stall_cycles", stall_cnt, 32'd2);
    check("ld_req_cycles",   req_cnt,   32'd1);
    check("ld_rd",           rd,        32'hDEAD_BEEF);
    check("ld_bus_we",       bus_we,    32'h0);
    check("ld_resp_bus_req", bus_req,   32'h0);
    check("ld_stable",       stable_ok, 32'h1);
    end_access();
    check("ld_idle_stall",   stall,     32'h0);
    check("ld_idle_bus_req", bus_req,   32'h0);

    // Store acknowledged after three wait cycles; rd must not change.
    run_access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 3, 32'h5A5A_5A5A);
    check("st_stall_cycles", stall_cnt, 32'd5);
    check("st_req_cycles",   req_cnt,   32'd4);
    check("st_bus_we",       bus_we,    32'h1);
    check("st_bus_wdata",    bus_wdata, 32'h1234_5678);
    check("st_stable",       stable_ok, 32'h1);
    check("st_rd_kept",      rd,        32'hDEAD_BEEF);
    check("st_err",          err,       32'h0);
    end_access();

    // Load and store together is a store.
    run_access(1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 1, 32'h1111_1111);
    check("both_stall_cycles", stall_cnt, 32'd3);
    check("both_bus_we",       bus_we,    32'h1);
    check("both_bus_wdata",    bus_wdata, 32'hCAFE_F00D);
    check("both_rd_kept",      rd,        32'hDEAD_BEEF);
    end_access();

    // Timeout: counts 0..4 in REQ, so five REQ cycles before RESP.
    run_access(1'b1, 1'b0, 32'h30, 32'h0, -1, 32'h0);
    check("to_req_cycles",   req_cnt,   32'd5);
    check("to_stall_cycles", stall_cnt, 32'd6);
    check("to_bus_req",      bus_req,   32'h0);
    check("to_err",          err,       32'h1);
    check("to_rd_zero",      rd,        32'h0);
    end_access();
    check("to_idle_stall",   stall,     32'h0);
    check("to_idle_bus_req", bus_req,   32'h0);

    // err stays set across a later good load.
    run_access(1'b1, 1'b0, 32'h34, 32'h0, 0, 32'h5555_AAAA);
    check("sticky_rd",  rd,  32'h5555_AAAA);
    check("sticky_err", err, 32'h1);
    end_access();

    // Reset in the middle of REQ abandons the transfer.
    mem_re = 1'b1;
    addr   = 32'h40;
    tick();
    tick();
    check("mid_bus_req", bus_req, 32'h1);
    reset  = 1'b1;
    mem_re = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_bus_req",  bus_req,  32'h0);
    check("mid_rst_stall",    stall,    32'h0);
    check("mid_rst_err",      err,      32'h0);
    check("mid_rst_rd",       rd,       32'h0);
    check("mid_rst_bus_addr", bus_addr, 32'h0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h9999_9999;
    tick();
    bus_ack = 1'b0;
    #1;
    check("late_ack_rd",      rd,      32'h0);
    check("late_ack_bus_req", bus_req, 32'h0);
    check("late_ack_err",     err,     32'h0);

    // Establish a known rd before the alignment scenario.
    run_access(1'b1, 1'b0, 32'h50, 32'h0, 0, 32'h0BAD_F00D);
    check("pre_align_rd", rd, 32'h0BAD_F00D);
    end_access();

    run_access(1'b1, 1'b0, 32'h13, 32'h0, 0, 32'h7777_7777);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_stall_cycles", stall_cnt, 32'd1);
    check("mis_req_cycles",   req_cnt,   32'd0);
    check("mis_err",          err,       32'h1);
    check("mis_rd_kept",      rd,        32'h0BAD_F00D);
`else
    check("mis_stall_cycles", stall_cnt, 32'd2);
    check("mis_bus_addr",     bus_addr,  32'h13);
    check("mis_rd",           rd,        32'h7777_7777);
    check("mis_err",          err,       32'h0);
`endif
    end_access();
    check("final_stall", stall, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
